// File: rtl/uart_sched_pkg.sv
// Shared types and constants for the UART TX scheduler.
//   state_e              : scheduler FSM state encoding
//   REQ_A / REQ_B        : requester identifiers (grant_id values)
//   WDOG_CYCLES_DEFAULT  : default WAIT_HI watchdog length
package uart_sched_pkg;

  typedef enum logic [1:0] {
    StIdle   = 2'd0,
    StLoad   = 2'd1,
    StWaitHi = 2'd2,
    StWaitLo = 2'd3
  } state_e;

  localparam logic REQ_A = 1'b0;
  localparam logic REQ_B = 1'b1;

  localparam int unsigned WDOG_CYCLES_DEFAULT = 16;

endpackage

// File: rtl/rr_arbiter_2.sv
// Two-way round-robin arbiter.
//   clk_i, rst_ni : clock, synchronous active-low reset
//   req_a_i/req_b_i : request lines
//   upd_i, upd_id_i : record upd_id_i as the most recent winner
//   gnt_o, gnt_id_o : some request present / identity of the winner
// The pointer resets to REQ_B so that A wins the first tie.
module rr_arbiter_2
  import uart_sched_pkg::*;
(
  input  logic clk_i,
  input  logic rst_ni,
  input  logic req_a_i,
  input  logic req_b_i,
  input  logic upd_i,
  input  logic upd_id_i,
  output logic gnt_o,
  output logic gnt_id_o
);

  logic last_q;

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      last_q <= REQ_B;
    end else if (upd_i) begin
      last_q <= upd_id_i;
    end
  end

  always_comb begin
    gnt_o = req_a_i | req_b_i;
    if (req_a_i && req_b_i) begin
      gnt_id_o = ~last_q;
    end else if (req_a_i) begin
      gnt_id_o = REQ_A;
    end else begin
      gnt_id_o = REQ_B;
    end
  end

endmodule

// File: rtl/uart_tx_scheduler.sv
// Shares one UART transmitter between requester A (one or two bytes) and
// requester B (one byte). Arbitrates round-robin, latches parity config per
// frame, and feeds bytes low-byte-first through the TX valid/busy handshake.
// Ports:
//   CLK, RST                     : clock, synchronous active-low reset
//   A_valid/A_data/A_two_bytes   : requester A frame, A_ack pulses on accept
//   B_valid/B_data               : requester B frame, B_ack pulses on accept
//   CFG_PAR_EN/CFG_PAR_TYP       : live parity config, latched at grant
//   TX_busy                      : busy from UART TX
//   TX_P_DATA/TX_Data_valid      : byte and load strobe to UART TX
//   PAR_EN/PAR_TYP               : per-frame latched parity config
//   sched_busy, grant_id, tx_err : status
// Optional: define UART_TX_WDOG_EN to abort a frame when TX_busy does not
// rise within WDOG_CYCLES cycles of WAIT_HI; otherwise tx_err is tied 0.
module uart_tx_scheduler
  import uart_sched_pkg::*;
#(
  parameter int unsigned Data_width  = 8,
  parameter int unsigned WDOG_CYCLES = WDOG_CYCLES_DEFAULT
) (
  input  logic                    CLK,
  input  logic                    RST,
  input  logic                    A_valid,
  input  logic [2*Data_width-1:0] A_data,
  input  logic                    A_two_bytes,
  output logic                    A_ack,
  input  logic                    B_valid,
  input  logic [Data_width-1:0]   B_data,
  output logic                    B_ack,
  input  logic                    CFG_PAR_EN,
  input  logic                    CFG_PAR_TYP,
  input  logic                    TX_busy,
  output logic [Data_width-1:0]   TX_P_DATA,
  output logic                    TX_Data_valid,
  output logic                    PAR_EN,
  output logic                    PAR_TYP,
  output logic                    sched_busy,
  output logic                    grant_id,
  output logic                    tx_err
);

  state_e                state_q, state_d;
  logic [Data_width-1:0] hi_q, hi_d;      // pending upper byte of an A frame
  logic                  more_q, more_d;  // upper byte still to be sent
  logic                  a_ack_q, a_ack_d, b_ack_q, b_ack_d;
  logic                  txv_q, txv_d;
  logic [Data_width-1:0] txd_q, txd_d;
  logic                  par_en_q, par_en_d, par_typ_q, par_typ_d;
  logic                  busy_q, busy_d;
  logic                  gid_q, gid_d;
  logic                  arb_gnt, arb_id, upd;

`ifdef UART_TX_WDOG_EN
  localparam int unsigned WdogW = (WDOG_CYCLES > 1) ? $clog2(WDOG_CYCLES) : 1;
  logic [WdogW-1:0] wdog_q, wdog_d;
  logic             err_q, err_d;
`else
  logic unused_wdog;
  assign unused_wdog = ^WDOG_CYCLES;
`endif

  rr_arbiter_2 u_arb (
    .clk_i   (CLK),
    .rst_ni  (RST),
    .req_a_i (A_valid),
    .req_b_i (B_valid),
    .upd_i   (upd),
    .upd_id_i(gid_q),
    .gnt_o   (arb_gnt),
    .gnt_id_o(arb_id)
  );

  always_comb begin
    state_d   = state_q;
    hi_d      = hi_q;
    more_d    = more_q;
    a_ack_d   = 1'b0;
    b_ack_d   = 1'b0;
    txv_d     = 1'b0;
    txd_d     = txd_q;
    par_en_d  = par_en_q;
    par_typ_d = par_typ_q;
    gid_d     = gid_q;
    upd       = 1'b0;
`ifdef UART_TX_WDOG_EN
    err_d     = 1'b0;
    wdog_d    = wdog_q;
`endif
    unique case (state_q)
      StIdle: begin
        if (!TX_busy && arb_gnt) begin
          gid_d     = arb_id;
          par_en_d  = CFG_PAR_EN;
          par_typ_d = CFG_PAR_TYP;
          txv_d     = 1'b1;
          state_d   = StLoad;
          if (arb_id == REQ_A) begin
            a_ack_d = 1'b1;
            txd_d   = A_data[Data_width-1:0];
            hi_d    = A_data[2*Data_width-1:Data_width];
            more_d  = A_two_bytes;
          end else begin
            b_ack_d = 1'b1;
            txd_d   = B_data;
            more_d  = 1'b0;
          end
        end
      end
      StLoad: begin
        state_d = StWaitHi;
`ifdef UART_TX_WDOG_EN
        wdog_d  = '0;
`endif
      end
      StWaitHi: begin
        if (TX_busy) begin
          state_d = StWaitLo;
`ifdef UART_TX_WDOG_EN
        end else if (wdog_q == WdogW'(WDOG_CYCLES - 1)) begin
          // TX never acknowledged the load: drop the rest of the frame
          err_d   = 1'b1;
          more_d  = 1'b0;
          upd     = 1'b1;
          state_d = StIdle;
        end else begin
          wdog_d = wdog_q + 1'b1;
`endif
        end
      end
      StWaitLo: begin
        if (!TX_busy) begin
          if (more_q) begin
            txd_d   = hi_q;
            txv_d   = 1'b1;
            more_d  = 1'b0;
            state_d = StLoad;
          end else begin
            upd     = 1'b1;
            state_d = StIdle;
          end
        end
      end
      default: state_d = StIdle;
    endcase
    busy_d = (state_d != StIdle);
  end

  always_ff @(posedge CLK) begin
    if (!RST) begin
      state_q   <= StIdle;
      hi_q      <= '0;
      more_q    <= 1'b0;
      a_ack_q   <= 1'b0;
      b_ack_q   <= 1'b0;
      txv_q     <= 1'b0;
      txd_q     <= '0;
      par_en_q  <= 1'b0;
      par_typ_q <= 1'b0;
      busy_q    <= 1'b0;
      gid_q     <= 1'b0;
`ifdef UART_TX_WDOG_EN
      wdog_q    <= '0;
      err_q     <= 1'b0;
`endif
    end else begin
      state_q   <= state_d;
      hi_q      <= hi_d;
      more_q    <= more_d;
      a_ack_q   <= a_ack_d;
      b_ack_q   <= b_ack_d;
      txv_q     <= txv_d;
      txd_q     <= txd_d;
      par_en_q  <= par_en_d;
      par_typ_q <= par_typ_d;
      busy_q    <= busy_d;
      gid_q     <= gid_d;
`ifdef UART_TX_WDOG_EN
      wdog_q    <= wdog_d;
      err_q     <= err_d;
`endif
    end
  end

  assign A_ack         = a_ack_q;
  assign B_ack         = b_ack_q;
  assign TX_P_DATA     = txd_q;
  assign TX_Data_valid = txv_q;
  assign PAR_EN        = par_en_q;
  assign PAR_TYP       = par_typ_q;
  assign sched_busy    = busy_q;
  assign grant_id      = gid_q;
`ifdef UART_TX_WDOG_EN
  assign tx_err        = err_q;
`else
  assign tx_err        = 1'b0;
`endif

endmodule

// File: tb/tb_uart_tx_scheduler.sv
module tb_uart_tx_scheduler;

  localparam int unsigned W = 8;

  logic           CLK = 1'b0;
  logic           RST;
  logic           A_valid, A_two_bytes, A_ack;
  logic [2*W-1:0] A_data;
  logic           B_valid, B_ack;
  logic [W-1:0]   B_data;
  logic           CFG_PAR_EN, CFG_PAR_TYP, TX_busy;
  logic [W-1:0]   TX_P_DATA;
  logic           TX_Data_valid, PAR_EN, PAR_TYP, sched_busy, grant_id, tx_err;

  int unsigned vec  = 0;
  int unsigned errs = 0;

  always #5 CLK = ~CLK;

  uart_tx_scheduler #(.Data_width(W), .WDOG_CYCLES(16)) dut (
    .CLK(CLK), .RST(RST),
    .A_valid(A_valid), .A_data(A_data), .A_two_bytes(A_two_bytes), .A_ack(A_ack),
    .B_valid(B_valid), .B_data(B_data), .B_ack(B_ack),
    .CFG_PAR_EN(CFG_PAR_EN), .CFG_PAR_TYP(CFG_PAR_TYP), .TX_busy(TX_busy),
    .TX_P_DATA(TX_P_DATA), .TX_Data_valid(TX_Data_valid),
    .PAR_EN(PAR_EN), .PAR_TYP(PAR_TYP), .sched_busy(sched_busy),
    .grant_id(grant_id), .tx_err(tx_err)
  );

  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  task automatic do_reset();
    RST = 1'b0; A_valid = 1'b0; A_data = '0; A_two_bytes = 1'b0;
    B_valid = 1'b0; B_data = '0; CFG_PAR_EN = 1'b0; CFG_PAR_TYP = 1'b0; TX_busy = 1'b0;
    step();
    step();
    RST = 1'b1;
  endtask

  // Acts as the UART TX for one byte: captures the load, then busy high 2 cycles.
  task automatic serve_byte(output bit ok, output logic [W-1:0] data, output logic aack,
                            output logic back, output logic gid, output logic pen,
                            output logic ptyp);
    ok = 1'b0; data = '0; aack = 1'b0; back = 1'b0; gid = 1'b0; pen = 1'b0; ptyp = 1'b0;
    for (int i = 0; i < 60; i++) begin
      @(negedge CLK);
      if (TX_Data_valid) begin
        ok = 1'b1; data = TX_P_DATA; aack = A_ack; back = B_ack;
        gid = grant_id; pen = PAR_EN; ptyp = PAR_TYP;
        break;
      end
    end
    if (ok) begin
      @(posedge CLK);
      #1 TX_busy = 1'b1;
      repeat (2) @(posedge CLK);
      #1 TX_busy = 1'b0;
    end
  endtask

  task automatic test_reset();
    do_reset();
    @(negedge CLK);
    vec++;
    if ({A_ack, B_ack, TX_P_DATA, TX_Data_valid, PAR_EN, PAR_TYP, sched_busy, grant_id,
         tx_err} !== '0) begin
      errs++;
      $display("FAIL reset_outputs: got %b required all zero",
               {A_ack, B_ack, TX_P_DATA, TX_Data_valid, PAR_EN, PAR_TYP, sched_busy,
                grant_id, tx_err});
    end
  endtask

  task automatic test_two_byte();
    bit ok; logic [W-1:0] b; logic aa, bb, g, pe, pt; int extra;
    do_reset();
    A_valid = 1'b1; A_data = 16'hBEEF; A_two_bytes = 1'b1;
    serve_byte(ok, b, aa, bb, g, pe, pt);
    vec++;
    if (!ok || b !== 8'hEF || aa !== 1'b1 || bb !== 1'b0 || g !== 1'b0) begin
      errs++;
      $display("FAIL two_byte_first: got ok=%0d byte=%h aack=%b back=%b gid=%b required 1 ef 1 0 0",
               ok, b, aa, bb, g);
    end
    A_valid = 1'b0; A_data = '0;
    serve_byte(ok, b, aa, bb, g, pe, pt);
    vec++;
    if (!ok || b !== 8'hBE || aa !== 1'b0) begin
      errs++;
      $display("FAIL two_byte_second: got ok=%0d byte=%h aack=%b required 1 be 0", ok, b, aa);
    end
    extra = 0;
    for (int i = 0; i < 8; i++) begin
      @(negedge CLK);
      if (TX_Data_valid || A_ack) extra++;
    end
    vec++;
    if (extra != 0 || sched_busy !== 1'b0) begin
      errs++;
      $display("FAIL two_byte_extra: got extra=%0d busy=%b required 0 0", extra, sched_busy);
    end
  endtask

  task automatic test_tie();
    bit ok; logic [W-1:0] b; logic aa, bb, g, pe, pt;
    logic [W-1:0] exp_b [4];
    logic         exp_g [4];
    exp_b[0] = 8'h12; exp_b[1] = 8'h34; exp_b[2] = 8'h56; exp_b[3] = 8'h78;
    exp_g[0] = 1'b0;  exp_g[1] = 1'b1;  exp_g[2] = 1'b0;  exp_g[3] = 1'b1;
    do_reset();
    A_valid = 1'b1; A_data = 16'h0012; A_two_bytes = 1'b0; B_valid = 1'b1; B_data = 8'h34;
    for (int k = 0; k < 4; k++) begin
      serve_byte(ok, b, aa, bb, g, pe, pt);
      vec++;
      if (!ok || b !== exp_b[k] || g !== exp_g[k] || aa !== ~exp_g[k] || bb !== exp_g[k]) begin
        errs++;
        $display("FAIL tie_grant%0d: got ok=%0d byte=%h gid=%b aack=%b back=%b required %h %b",
                 k, ok, b, g, aa, bb, exp_b[k], exp_g[k]);
      end
      if (exp_g[k]) B_valid = 1'b0;
      else A_valid = 1'b0;
      if (k == 1) begin
        A_valid = 1'b1; A_data = 16'h0056; B_valid = 1'b1; B_data = 8'h78;
      end
    end
    repeat (4) @(negedge CLK);
    vec++;
    if (grant_id !== 1'b1 || sched_busy !== 1'b0) begin
      errs++;
      $display("FAIL tie_final: got gid=%b busy=%b required 1 0", grant_id, sched_busy);
    end
  endtask

  task automatic test_parity_hold();
    bit ok, found; logic [W-1:0] b; logic aa, bb, g, pe, pt;
    do_reset();
    CFG_PAR_EN = 1'b1; CFG_PAR_TYP = 1'b1; B_valid = 1'b1; B_data = 8'hA5;
    found = 1'b0;
    for (int i = 0; i < 20 && !found; i++) begin
      @(negedge CLK);
      found = TX_Data_valid;
    end
    vec++;
    if (!found || TX_P_DATA !== 8'hA5 || B_ack !== 1'b1 || PAR_EN !== 1'b1 || PAR_TYP !== 1'b1)
    begin
      errs++;
      $display("FAIL par_load: got found=%0d byte=%h back=%b pen=%b ptyp=%b required 1 a5 1 1 1",
               found, TX_P_DATA, B_ack, PAR_EN, PAR_TYP);
    end
    @(posedge CLK);
    #1 B_valid = 1'b0; TX_busy = 1'b1;
    step();
    CFG_PAR_TYP = 1'b0;  // now in WAIT_LO
    @(negedge CLK);
    vec++;
    if (PAR_TYP !== 1'b1 || sched_busy !== 1'b1) begin
      errs++;
      $display("FAIL par_wait_lo: got ptyp=%b busy=%b required 1 1", PAR_TYP, sched_busy);
    end
    @(posedge CLK);
    #1 TX_busy = 1'b0;
    @(posedge CLK);
    @(negedge CLK);
    vec++;
    if (PAR_TYP !== 1'b1 || PAR_EN !== 1'b1 || sched_busy !== 1'b0) begin
      errs++;
      $display("FAIL par_idle: got ptyp=%b pen=%b busy=%b required 1 1 0",
               PAR_TYP, PAR_EN, sched_busy);
    end
    @(posedge CLK);
    #1 B_valid = 1'b1; B_data = 8'h5A;
    serve_byte(ok, b, aa, bb, g, pe, pt);
    B_valid = 1'b0;
    vec++;
    if (!ok || b !== 8'h5A || pe !== 1'b1 || pt !== 1'b0) begin
      errs++;
      $display("FAIL par_regrant: got ok=%0d byte=%h pen=%b ptyp=%b required 1 5a 1 0",
               ok, b, pe, pt);
    end
  endtask

  task automatic test_reset_mid_frame();
    bit ok, found; logic [W-1:0] b; logic aa, bb, g, pe, pt;
    do_reset();
    A_valid = 1'b1; A_data = 16'h1357; A_two_bytes = 1'b1;
    found = 1'b0;
    for (int i = 0; i < 20 && !found; i++) begin
      @(negedge CLK);
      found = TX_Data_valid & A_ack;
    end
    step();
    step();  // in WAIT_HI, TX never raises busy
    RST = 1'b0;
    step();
    RST = 1'b1;
    @(negedge CLK);
    vec++;
    if (!found || {A_ack, B_ack, TX_P_DATA, TX_Data_valid, PAR_EN, PAR_TYP, sched_busy,
                   grant_id, tx_err} !== '0) begin
      errs++;
      $display("FAIL reset_mid: got found=%0d outs=%b required 1 and all zero", found,
               {A_ack, B_ack, TX_P_DATA, TX_Data_valid, PAR_EN, PAR_TYP, sched_busy,
                grant_id, tx_err});
    end
    serve_byte(ok, b, aa, bb, g, pe, pt);
    A_valid = 1'b0;
    vec++;
    if (!ok || b !== 8'h57 || aa !== 1'b1) begin
      errs++;
      $display("FAIL reset_regrant: got ok=%0d byte=%h aack=%b required 1 57 1", ok, b, aa);
    end
    serve_byte(ok, b, aa, bb, g, pe, pt);
    vec++;
    if (!ok || b !== 8'h13 || aa !== 1'b0) begin
      errs++;
      $display("FAIL reset_regrant_hi: got ok=%0d byte=%h aack=%b required 1 13 0", ok, b, aa);
    end
  endtask

  task automatic test_busy_block();
    int bad;
    do_reset();
    TX_busy = 1'b1; B_valid = 1'b1; B_data = 8'hC3;
    bad = 0;
    for (int i = 0; i < 5; i++) begin
      @(negedge CLK);
      if (B_ack !== 1'b0 || sched_busy !== 1'b0) bad++;
    end
    vec++;
    if (bad != 0) begin
      errs++;
      $display("FAIL busy_block_hold: got %0d granted cycles required 0", bad);
    end
    @(posedge CLK);
    #1 TX_busy = 1'b0;
    @(negedge CLK);
    vec++;
    if (B_ack !== 1'b0) begin
      errs++;
      $display("FAIL busy_block_early: got back=%b required 0", B_ack);
    end
    @(negedge CLK);
    vec++;
    if (B_ack !== 1'b1 || TX_Data_valid !== 1'b1 || TX_P_DATA !== 8'hC3) begin
      errs++;
      $display("FAIL busy_block_grant: got back=%b txv=%b byte=%h required 1 1 c3",
               B_ack, TX_Data_valid, TX_P_DATA);
    end
    @(posedge CLK);
    #1 B_valid = 1'b0; TX_busy = 1'b1;
    repeat (2) @(posedge CLK);
    #1 TX_busy = 1'b0;
    repeat (3) step();
  endtask

  task automatic test_wdog();
    bit found; int at, extra;
    do_reset();
    A_valid = 1'b1; A_data = 16'hCAFE; A_two_bytes = 1'b1;
    found = 1'b0;
    for (int i = 0; i < 20 && !found; i++) begin
      @(negedge CLK);
      found = TX_Data_valid;
    end
    A_valid = 1'b0;
    at = -1; extra = 0;
`ifdef UART_TX_WDOG_EN
    for (int i = 1; i <= 40; i++) begin
      @(negedge CLK);
      if (TX_Data_valid) extra++;
      if (tx_err) begin
        at = i;
        break;
      end
    end
    vec++;
    if (!found || at != 17 || extra != 0 || sched_busy !== 1'b0) begin
      errs++;
      $display("FAIL wdog_abort: got found=%0d at=%0d extra=%0d busy=%b required 1 17 0 0",
               found, at, extra, sched_busy);
    end
    for (int i = 0; i < 10; i++) begin
      @(negedge CLK);
      if (TX_Data_valid || tx_err || sched_busy) extra++;
    end
    vec++;
    if (extra != 0) begin
      errs++;
      $display("FAIL wdog_after: got %0d active cycles required 0", extra);
    end
`else
    for (int i = 1; i <= 40; i++) begin
      @(negedge CLK);
      if (TX_Data_valid || tx_err || !sched_busy) extra++;
    end
    vec++;
    if (!found || extra != 0) begin
      errs++;
      $display("FAIL wait_hi_hold: got found=%0d bad=%0d required 1 0", found, extra);
    end
    @(posedge CLK);
    #1 TX_busy = 1'b1;
    repeat (2) @(posedge CLK);
    #1 TX_busy = 1'b0;
    for (int i = 0; i < 10 && !(TX_Data_valid === 1'b1); i++) @(negedge CLK);
    vec++;
    if (TX_Data_valid !== 1'b1 || TX_P_DATA !== 8'hCA) begin
      errs++;
      $display("FAIL wait_hi_resume: got txv=%b byte=%h required 1 ca", TX_Data_valid, TX_P_DATA);
    end
    @(posedge CLK);
    #1 TX_busy = 1'b1;
    repeat (2) @(posedge CLK);
    #1 TX_busy = 1'b0;
    repeat (3) step();
`endif
  endtask

  // Random traffic against a transaction-level model: round-robin winner
  // choice, byte order per frame, per-frame parity snapshot, no starvation.
  task automatic test_random();
    logic         m_last, m_pen, m_ptyp, w, exp_w, ptwo, pa, pb, pen_s, ptyp_s;
    logic [W-1:0] expq [$];
    logic [W-1:0] e, exp_b, pbd;
    logic [2*W-1:0] pad;
    bit           a_drop, b_drop, pend, stop;
    int           rw, rl, aw, bw, frames;
    do_reset();
    m_last = 1'b1; m_pen = 1'b0; m_ptyp = 1'b0;
    pa = 1'b0; pb = 1'b0; pad = '0; pbd = '0; ptwo = 1'b0; pen_s = 1'b0; ptyp_s = 1'b0;
    a_drop = 1'b0; b_drop = 1'b0; pend = 1'b0; rw = 0; rl = 0; aw = 0; bw = 0; frames = 0;
    for (int cyc = 0; cyc < 3000; cyc++) begin
      @(posedge CLK);
      #1;
      stop = (cyc >= 2700);
      if (a_drop) begin
        A_valid = 1'b0; a_drop = 1'b0;
      end else if (!A_valid && !stop && $urandom_range(0, 3) == 0) begin
        A_valid = 1'b1; A_data = 16'($urandom); A_two_bytes = 1'($urandom);
      end
      if (b_drop) begin
        B_valid = 1'b0; b_drop = 1'b0;
      end else if (!B_valid && !stop && $urandom_range(0, 3) == 0) begin
        B_valid = 1'b1; B_data = 8'($urandom);
      end
      if ($urandom_range(0, 7) == 0) begin
        CFG_PAR_EN = 1'($urandom); CFG_PAR_TYP = 1'($urandom);
      end
      if (rw > 0) begin
        TX_busy = 1'b0; rw--;
      end else if (rl > 0) begin
        TX_busy = 1'b1; rl--;
      end else begin
        TX_busy = 1'b0; pend = 1'b0;
      end

      @(negedge CLK);
      if (A_ack || B_ack) begin
        vec++;
        if (A_ack && B_ack) begin
          errs++;
          $display("FAIL rnd_double_ack: got aack=1 back=1 required one");
        end
        w = B_ack;
        exp_w = (pa && pb) ? ~m_last : (pa ? 1'b0 : 1'b1);
        vec++;
        if (!(pa || pb) || w !== exp_w || grant_id !== w) begin
          errs++;
          $display("FAIL rnd_arb cyc=%0d: got winner=%b gid=%b required %b (reqA=%b reqB=%b)",
                   cyc, w, grant_id, exp_w, pa, pb);
        end
        exp_b = w ? pbd : pad[W-1:0];
        vec++;
        if (TX_Data_valid !== 1'b1 || TX_P_DATA !== exp_b) begin
          errs++;
          $display("FAIL rnd_first_byte cyc=%0d: got txv=%b byte=%h required 1 %h",
                   cyc, TX_Data_valid, TX_P_DATA, exp_b);
        end
        if (!w && ptwo) expq.push_back(pad[2*W-1:W]);
        m_last = w; m_pen = pen_s; m_ptyp = ptyp_s;
        if (w) b_drop = 1'b1;
        else a_drop = 1'b1;
        frames++;
      end else if (TX_Data_valid) begin
        vec++;
        if (expq.size() == 0) begin
          errs++;
          $display("FAIL rnd_unexpected_load cyc=%0d: got byte=%h required no load", cyc,
                   TX_P_DATA);
        end else begin
          e = expq.pop_front();
          if (TX_P_DATA !== e) begin
            errs++;
            $display("FAIL rnd_second_byte cyc=%0d: got %h required %h", cyc, TX_P_DATA, e);
          end
        end
      end
      if (TX_Data_valid) begin
        vec++;
        if (pend) begin
          errs++;
          $display("FAIL rnd_load_while_busy cyc=%0d: got load required none", cyc);
        end
        pend = 1'b1; rw = $urandom_range(0, 2); rl = $urandom_range(1, 3);
      end
      vec++;
      if (PAR_EN !== m_pen || PAR_TYP !== m_ptyp) begin
        errs++;
        $display("FAIL rnd_parity cyc=%0d: got %b%b required %b%b", cyc, PAR_EN, PAR_TYP,
                 m_pen, m_ptyp);
      end
      aw = (A_valid && !A_ack) ? aw + 1 : 0;
      bw = (B_valid && !B_ack) ? bw + 1 : 0;
      vec++;
      if (aw > 80 || bw > 80) begin
        errs++;
        $display("FAIL rnd_starve cyc=%0d: got waits %0d/%0d required <= 80", cyc, aw, bw);
        aw = 0; bw = 0;
      end
      pa = A_valid; pb = B_valid; pad = A_data; pbd = B_data; ptwo = A_two_bytes;
      pen_s = CFG_PAR_EN; ptyp_s = CFG_PAR_TYP;
    end
    vec++;
    if (expq.size() != 0 || frames < 50 || sched_busy !== 1'b0) begin
      errs++;
      $display("FAIL rnd_drain: got pending=%0d frames=%0d busy=%b required 0 >=50 0",
               expq.size(), frames, sched_busy);
    end
  endtask

  initial begin
    test_reset();
    test_two_byte();
    test_tie();
    test_parity_hold();
    test_reset_mid_frame();
    test_busy_block();
    test_wdog();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vec, errs);
    $finish;
  end

endmodule
